// File: rtl/hpi_defs_pkg.sv
// hpi_defs: shared definitions for the HPI device-side responder.
//   - HPI register codes as seen on hpi_address[1:0]
//   - STATUS register bit positions
//   - access FSM state encoding
//   - helper that assembles the STATUS read word
package hpi_defs;

  localparam logic [1:0] HPI_REG_DATA    = 2'b00;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'b01;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'b10;
  localparam logic [1:0] HPI_REG_STATUS  = 2'b11;

  localparam int STATUS_TX_FULL = 0;
  localparam int STATUS_RX_FULL = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_COMMIT = 2'd3
  } hpi_state_t;

  function automatic logic [15:0] status_word(input logic rx_full, input logic tx_full);
    logic [15:0] w;
    w = '0;
    w[STATUS_RX_FULL] = rx_full;
    w[STATUS_TX_FULL] = tx_full;
    return w;
  endfunction

endpackage

// File: rtl/hpi_sync_bus.sv
// hpi_sync_bus: SYNC_STAGES-deep synchronizer for the asynchronous HPI bus.
// Ports:
//   clk, reset   responder clock, synchronous active-high reset
//   strobe_in    {csn, oen, wen}, active-low strobes from the master
//   bus_in       {address, data} sampled alongside the strobes
//   strobe_out   synchronized strobes (forced inactive-high during reset)
//   bus_out      synchronized address/data (no reset, pure datapath)
module hpi_sync_bus #(
  parameter int SYNC_STAGES = 2,
  parameter int BUS_W       = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       strobe_in,
  input  logic [BUS_W-1:0] bus_in,
  output logic [2:0]       strobe_out,
  output logic [BUS_W-1:0] bus_out
);

  logic [2:0]       strobe_pipe [SYNC_STAGES];
  logic [BUS_W-1:0] bus_pipe    [SYNC_STAGES];

  // Strobes reset to the released level so no access is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) strobe_pipe[i] <= 3'b111;
    end else begin
      strobe_pipe[0] <= strobe_in;
      for (int i = 1; i < SYNC_STAGES; i++) strobe_pipe[i] <= strobe_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    bus_pipe[0] <= bus_in;
    for (int i = 1; i < SYNC_STAGES; i++) bus_pipe[i] <= bus_pipe[i-1];
  end

  assign strobe_out = strobe_pipe[SYNC_STAGES-1];
  assign bus_out    = bus_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/hpi_responder.sv
// hpi_responder: device-side (CY7C67300-style) HPI responder with a backing
// auto-incrementing word RAM and a two-way mailbox.
// Ports:
//   clk, reset                   responder clock, synchronous active-high reset
//   hpi_csn/oen/wen              active-low HPI strobes, asynchronous to clk
//   hpi_address, hpi_data_in     register select and write data from the master
//   hpi_data_out, hpi_data_oe    registered read data and its tristate enable
//   hpi_irq                      high while a device->host mailbox word is pending
//   mbx_rx_valid/data/ack        host->device mailbox towards the local side
//   mbx_tx_write/data            local side posts a device->host mailbox word
module hpi_responder
  import hpi_defs::*;
#(
  parameter int MEM_AW      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hpi_csn,
  input  logic        hpi_oen,
  input  logic        hpi_wen,
  input  logic [1:0]  hpi_address,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic        hpi_irq,
  output logic        mbx_rx_valid,
  output logic [15:0] mbx_rx_data,
  input  logic        mbx_rx_ack,
  input  logic        mbx_tx_write,
  input  logic [15:0] mbx_tx_data
);

  logic        csn_s, oen_s, wen_s;
  logic [1:0]  addr_s;
  logic [15:0] data_s;
  logic        rd_act, wr_act;

  hpi_state_t  state;
  logic        acc_wr;
  logic [1:0]  acc_reg;
  logic [15:0] acc_data;
  logic [15:0] address_reg;
  logic        tx_full, rx_full;
  logic [15:0] tx_data, rx_data;

  logic [15:0]       mem [2**MEM_AW];
  logic [15:0]       ram_q;
  logic [MEM_AW-1:0] ram_idx;
  logic              commit;
  logic              ram_we;
  logic [15:0]       rd_mux;

  // Stage boundary: asynchronous HPI pins -> clk domain
  hpi_sync_bus #(
    .SYNC_STAGES (SYNC_STAGES),
    .BUS_W       (18)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .strobe_in  ({hpi_csn, hpi_oen, hpi_wen}),
    .bus_in     ({hpi_address, hpi_data_in}),
    .strobe_out ({csn_s, oen_s, wen_s}),
    .bus_out    ({addr_s, data_s})
  );

  // Both strobes low at once is treated as neither read nor write.
  assign rd_act = ~csn_s & ~oen_s &  wen_s;
  assign wr_act = ~csn_s & ~wen_s &  oen_s;

  assign ram_idx = address_reg[MEM_AW:1];
  assign commit  = (state == ST_COMMIT);
  assign ram_we  = commit & ~reset & acc_wr & (acc_reg == HPI_REG_DATA);

  always_comb begin
    rd_mux = '0;
    case (addr_s)
      HPI_REG_DATA:    rd_mux = ram_q;
      HPI_REG_MAILBOX: rd_mux = tx_data;
      HPI_REG_ADDRESS: rd_mux = address_reg;
      default:         rd_mux = status_word(rx_full, tx_full);
    endcase
  end

  // Stage boundary: RAM with one-clock read latency; contents are never reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= acc_data;
    ram_q <= mem[ram_idx];
  end

  // Stage boundary: access FSM, register file and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      acc_wr       <= 1'b0;
      acc_reg      <= '0;
      acc_data     <= '0;
      address_reg  <= '0;
      tx_full      <= 1'b0;
      tx_data      <= '0;
      rx_full      <= 1'b0;
      rx_data      <= '0;
      hpi_data_out <= '0;
      hpi_data_oe  <= 1'b0;
    end else begin
      hpi_data_oe <= rd_act;
      if (rd_act) hpi_data_out <= rd_mux;

      // Keep the address/data of the last active cycle of the current access;
      // a strobe of the other kind must not overwrite what is about to commit.
      if ((rd_act && state != ST_WRITE) || (wr_act && state != ST_READ)) begin
        acc_reg  <= addr_s;
        acc_data <= data_s;
      end

      case (state)
        ST_IDLE: begin
          if (rd_act) begin
            state  <= ST_READ;
            acc_wr <= 1'b0;
          end else if (wr_act) begin
            state  <= ST_WRITE;
            acc_wr <= 1'b1;
          end
        end
        ST_READ:  if (!rd_act) state <= ST_COMMIT;
        ST_WRITE: if (!wr_act) state <= ST_COMMIT;
        default:  state <= ST_IDLE;
      endcase

      // DATA reads and writes both auto-increment; address_reg wraps at 16 bits.
      if (commit) begin
        if (acc_reg == HPI_REG_DATA)
          address_reg <= address_reg + 16'd2;
        else if (acc_wr && acc_reg == HPI_REG_ADDRESS)
          address_reg <= acc_data & 16'hFFFE;
      end

      // A local post beats a simultaneous host MAILBOX read completion.
      if (mbx_tx_write) begin
        tx_data <= mbx_tx_data;
        tx_full <= 1'b1;
      end else if (commit && !acc_wr && acc_reg == HPI_REG_MAILBOX) begin
        tx_full <= 1'b0;
      end

      // A host MAILBOX write beats a simultaneous local ack.
      if (commit && acc_wr && acc_reg == HPI_REG_MAILBOX) begin
        rx_data <= acc_data;
        rx_full <= 1'b1;
      end else if (mbx_rx_ack) begin
        rx_full <= 1'b0;
      end
    end
  end

  assign hpi_irq      = tx_full;
  assign mbx_rx_valid = rx_full;
  assign mbx_rx_data  = rx_data;

endmodule
